ysyx_22040750_lsu_axi_master: RTL and testbench

- Single-outstanding AXI-lite-style initiator between the pipeline LSU and memory-mapped responders (CLINT, data memory).
- Accepts one load/store request on a valid/ready port and sequences the AR/R or AW/W/B channels.
- Returns read data or write completion on a response valid/ready port.
- Moore FSM: no combinational path from any AXI input to any AXI output.

---
 rtl/ysyx_22040750_lsu_axi_master_if.sv | 53 +++++
 rtl/ysyx_22040750_lsu_axi_master.sv | 78 +++++++
 tb/tb_ysyx_22040750_lsu_axi_master.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22040750_lsu_axi_master_if.sv
// LSU request/response and AXI-lite channel bundle for the LSU AXI master.
// The master modport is the initiator's view; slave is the LSU + responder side.
interface ysyx_22040750_lsu_axi_master_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64
);
    logic                  I_req_valid;
    logic                  O_req_ready;
    logic                  I_req_wen;
    logic [ADDR_W-1:0]     I_req_addr;
    logic [DATA_W-1:0]     I_req_wdata;
    logic [DATA_W/8-1:0]   I_req_wstrb;
    logic                  O_resp_valid;
    logic                  I_resp_ready;
    logic [DATA_W-1:0]     O_resp_rdata;
    logic [ADDR_W-1:0]     O_araddr;
    logic                  O_arvalid;
    logic                  I_arready;
    logic [DATA_W-1:0]     I_rdata;
    logic                  I_rvalid;
    logic                  O_rready;
    logic [ADDR_W-1:0]     O_awaddr;
    logic                  O_awvalid;
    logic                  I_awready;
    logic [DATA_W-1:0]     O_wdata;
    logic [DATA_W/8-1:0]   O_wstrb;
    logic                  O_wvalid;
    logic                  I_wready;
    logic                  I_bvalid;
    logic                  O_bready;

    modport master (
        input  I_req_valid, I_req_wen, I_req_addr, I_req_wdata, I_req_wstrb,
        output O_req_ready,
        output O_resp_valid, O_resp_rdata,
        input  I_resp_ready,
        output O_araddr, O_arvalid, O_rready,
        input  I_arready, I_rdata, I_rvalid,
        output O_awaddr, O_awvalid, O_wdata, O_wstrb, O_wvalid, O_bready,
        input  I_awready, I_wready, I_bvalid
    );

    modport slave (
        output I_req_valid, I_req_wen, I_req_addr, I_req_wdata, I_req_wstrb,
        input  O_req_ready,
        input  O_resp_valid, O_resp_rdata,
        output I_resp_ready,
        input  O_araddr, O_arvalid, O_rready,
        output I_arready, I_rdata, I_rvalid,
        input  O_awaddr, O_awvalid, O_wdata, O_wstrb, O_wvalid, O_bready,
        output I_awready, I_wready, I_bvalid
    );
endinterface

// File: rtl/ysyx_22040750_lsu_axi_master.sv
// Single-outstanding AXI-lite initiator for the LSU; Moore FSM so every AXI
// output comes from registers and never from an AXI input.
module ysyx_22040750_lsu_axi_master #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64
) (
    input logic                              I_clk,
    input logic                              I_rst,
    ysyx_22040750_lsu_axi_master_if.master   bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AR   = 3'd1;
    localparam logic [2:0] S_R    = 3'd2;
    localparam logic [2:0] S_AW   = 3'd3;
    localparam logic [2:0] S_W    = 3'd4;
    localparam logic [2:0] S_B    = 3'd5;
    localparam logic [2:0] S_RSP  = 3'd6;

    logic [2:0]          state_q;
    logic [2:0]          state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                req_fire;

    assign req_fire = (state_q == S_IDLE) && bus.I_req_valid;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.I_req_valid)  state_d = bus.I_req_wen ? S_AW : S_AR;
            S_AR:   if (bus.I_arready)    state_d = S_R;
            S_R:    if (bus.I_rvalid)     state_d = S_RSP;
            S_AW:   if (bus.I_awready)    state_d = S_W;
            // bvalid may arrive together with the W handshake; skip B then
            S_W:    if (bus.I_wready)     state_d = bus.I_bvalid ? S_RSP : S_B;
            S_B:    if (bus.I_bvalid)     state_d = S_RSP;
            S_RSP:  if (bus.I_resp_ready) state_d = S_IDLE;
            default:                      state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (req_fire) begin
                addr_q  <= bus.I_req_addr;
                wdata_q <= bus.I_req_wdata;
                wstrb_q <= bus.I_req_wstrb;
                // stores report zero data, so clear the response register here
                rdata_q <= '0;
            end
            if ((state_q == S_R) && bus.I_rvalid) begin
                rdata_q <= bus.I_rdata;
            end
        end
    end

    assign bus.O_req_ready  = (state_q == S_IDLE) && !I_rst;
    assign bus.O_resp_valid = (state_q == S_RSP);
    assign bus.O_resp_rdata = rdata_q;
    assign bus.O_arvalid    = (state_q == S_AR);
    assign bus.O_araddr     = addr_q;
    assign bus.O_rready     = (state_q == S_R);
    assign bus.O_awvalid    = (state_q == S_AW);
    assign bus.O_awaddr     = addr_q;
    assign bus.O_wvalid     = (state_q == S_W);
    assign bus.O_wdata      = wdata_q;
    assign bus.O_wstrb      = wstrb_q;
    assign bus.O_bready     = (state_q == S_W) || (state_q == S_B);
endmodule

// File: tb/tb_ysyx_22040750_lsu_axi_master.sv
// Scoreboard bench: LSU driver, memory responder with per-transaction delays,
// protocol checker and response monitor against a flat memory reference model.
module tb_ysyx_22040750_lsu_axi_master;
    logic clk;
    logic rst;

    ysyx_22040750_lsu_axi_master_if #(.ADDR_W(32), .DATA_W(64)) bus();

    ysyx_22040750_lsu_axi_master #(.ADDR_W(32), .DATA_W(64)) dut (
        .I_clk (clk),
        .I_rst (rst),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [63:0] data;
        int          lat;
        int unsigned req_cyc;
    } exp_t;
    exp_t sb_q[$];

    logic [63:0] ref_mem[logic [31:0]];
    logic [63:0] rsp_mem[logic [31:0]];

    // per-transaction delays seen by the responder and the LSU side
    int unsigned ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0, rsp_dly = 0;
    bit junk_en = 0;

    // ---------------- responder ----------------
    int unsigned ar_cnt, r_cnt, aw_cnt, w_cnt, b_left;
    bit          b_pend, aw_seen;
    logic [31:0] ar_addr, aw_addr;

    initial begin
        bus.I_arready = 0; bus.I_rvalid = 0; bus.I_rdata = '0;
        bus.I_awready = 0; bus.I_wready = 0; bus.I_bvalid = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.I_arready = 0; bus.I_rvalid = 0; bus.I_rdata = '0;
                bus.I_awready = 0; bus.I_wready = 0; bus.I_bvalid = 0;
                ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_left = 0;
                b_pend = 0; aw_seen = 0;
            end else begin
                if (bus.O_arvalid) begin
                    bus.I_arready = (ar_cnt == ar_dly);
                    if (ar_cnt == ar_dly) ar_addr = bus.O_araddr;
                    ar_cnt++;
                end else begin
                    ar_cnt = 0;
                    bus.I_arready = junk_en && ($urandom_range(1) == 1);
                end

                if (bus.O_rready) begin
                    bus.I_rvalid = (r_cnt == r_dly);
                    if (r_cnt == r_dly)
                        bus.I_rdata = rsp_mem.exists(ar_addr) ? rsp_mem[ar_addr] : 64'h0;
                    else
                        bus.I_rdata = {$urandom, $urandom};
                    r_cnt++;
                end else begin
                    r_cnt = 0;
                    bus.I_rvalid = junk_en && ($urandom_range(1) == 1);
                    bus.I_rdata  = {$urandom, $urandom};
                end

                if (bus.O_awvalid) begin
                    bus.I_awready = (aw_cnt == aw_dly);
                    if (aw_cnt == aw_dly) begin
                        aw_addr = bus.O_awaddr;
                        aw_seen = 1;
                    end
                    aw_cnt++;
                end else begin
                    aw_cnt = 0;
                    bus.I_awready = junk_en && ($urandom_range(1) == 1);
                end

                if (bus.O_wvalid) begin
                    if (w_cnt == 0) chk("w_after_aw", aw_seen, 1);
                    if (w_cnt == w_dly) begin
                        logic [63:0] word;
                        bus.I_wready = 1;
                        word = rsp_mem.exists(aw_addr) ? rsp_mem[aw_addr] : 64'h0;
                        for (int unsigned i = 0; i < 8; i++)
                            if (bus.O_wstrb[i]) word[i*8 +: 8] = bus.O_wdata[i*8 +: 8];
                        rsp_mem[aw_addr] = word;
                        aw_seen = 0;
                        if (b_dly == 0) begin
                            bus.I_bvalid = 1;
                        end else begin
                            bus.I_bvalid = 0;
                            b_pend = 1;
                            b_left = b_dly;
                        end
                    end else begin
                        bus.I_wready = 0;
                        bus.I_bvalid = 0;
                    end
                    w_cnt++;
                end else begin
                    w_cnt = 0;
                    bus.I_wready = 0;
                    if (b_pend) begin
                        b_left--;
                        bus.I_bvalid = (b_left == 0);
                        if (b_left == 0) b_pend = 0;
                    end else begin
                        bus.I_bvalid = junk_en && !bus.O_bready && ($urandom_range(1) == 1);
                    end
                end
            end
        end
    end

    // ---------------- LSU response side ----------------
    int unsigned rsp_cnt;
    initial begin
        bus.I_resp_ready = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.I_resp_ready = 0;
                rsp_cnt = 0;
            end else if (bus.O_resp_valid) begin
                bus.I_resp_ready = (rsp_cnt == rsp_dly);
                rsp_cnt++;
            end else begin
                rsp_cnt = 0;
                bus.I_resp_ready = junk_en && ($urandom_range(1) == 1);
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    bit          rsp_seen;
    int unsigned first_cyc;
    initial begin
        rsp_seen = 0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                rsp_seen = 0;
            end else if (bus.O_resp_valid) begin
                if (!rsp_seen) begin
                    rsp_seen  = 1;
                    first_cyc = cyc;
                end
                if (bus.I_resp_ready) begin
                    rsp_seen = 0;
                    if (sb_q.size() == 0) begin
                        chk("resp_unexpected", 1, 0);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        chk("resp_rdata", bus.O_resp_rdata, e.data);
                        chk("resp_latency", 64'(int'(first_cyc - e.req_cyc)), 64'(e.lat));
                    end
                end
            end
        end
    end

    // ---------------- protocol checker ----------------
    logic        p_arv, p_arr, p_awv, p_awr, p_wv, p_wr, p_rr, p_rv, p_rspv, p_rspr;
    logic [31:0] p_araddr, p_awaddr;
    logic [63:0] p_wdata, p_rdata;
    logic [7:0]  p_wstrb;
    initial begin
        p_arv = 0; p_awv = 0; p_wv = 0; p_rr = 0; p_rspv = 0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                p_arv = 0; p_awv = 0; p_wv = 0; p_rr = 0; p_rspv = 0;
            end else begin
                if (p_arv && !p_arr) begin
                    chk("ar_hold_valid", bus.O_arvalid, 1);
                    chk("ar_hold_addr", bus.O_araddr, p_araddr);
                end
                if (p_rr && !p_rv) chk("r_hold_ready", bus.O_rready, 1);
                if (p_awv && !p_awr) begin
                    chk("aw_hold_valid", bus.O_awvalid, 1);
                    chk("aw_hold_addr", bus.O_awaddr, p_awaddr);
                end
                if (p_wv && !p_wr) begin
                    chk("w_hold_valid", bus.O_wvalid, 1);
                    chk("w_hold_data", bus.O_wdata, p_wdata);
                    chk("w_hold_strb", bus.O_wstrb, p_wstrb);
                end
                if (p_rspv && !p_rspr) begin
                    chk("rsp_hold_valid", bus.O_resp_valid, 1);
                    chk("rsp_hold_rdata", bus.O_resp_rdata, p_rdata);
                end
                if (bus.O_resp_valid)
                    chk("rsp_quiet_bus", {bus.O_req_ready, bus.O_arvalid, bus.O_rready,
                                          bus.O_awvalid, bus.O_wvalid, bus.O_bready}, 0);
                if (bus.O_bready && !bus.O_wvalid)
                    chk("b_state_bready_only", {bus.O_arvalid, bus.O_awvalid, bus.O_resp_valid}, 0);
                p_arv = bus.O_arvalid;  p_arr = bus.I_arready;  p_araddr = bus.O_araddr;
                p_awv = bus.O_awvalid;  p_awr = bus.I_awready;  p_awaddr = bus.O_awaddr;
                p_wv  = bus.O_wvalid;   p_wr  = bus.I_wready;
                p_wdata = bus.O_wdata;  p_wstrb = bus.O_wstrb;
                p_rr  = bus.O_rready;   p_rv  = bus.I_rvalid;
                p_rspv = bus.O_resp_valid; p_rspr = bus.I_resp_ready; p_rdata = bus.O_resp_rdata;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic wait_idle();
        for (int unsigned t = 0; t < 300 && sb_q.size() != 0; t++) @(negedge clk);
        if (sb_q.size() != 0) begin
            chk("drain_timeout", sb_q.size(), 0);
            sb_q.delete();
        end
    endtask

    task automatic do_req(input bit wen, input logic [31:0] addr, input logic [63:0] wdata,
                          input logic [7:0] wstrb, input int unsigned ar, input int unsigned r,
                          input int unsigned aw, input int unsigned w, input int unsigned b,
                          input int unsigned rs);
        bit   ok;
        exp_t e;
        wait_idle();
        @(negedge clk);
        ar_dly = ar; r_dly = r; aw_dly = aw; w_dly = w; b_dly = b; rsp_dly = rs;
        bus.I_req_valid = 1; bus.I_req_wen = wen; bus.I_req_addr = addr;
        bus.I_req_wdata = wdata; bus.I_req_wstrb = wstrb;
        ok = 0;
        for (int unsigned t = 0; t < 50; t++) begin
            if (bus.O_req_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            chk("req_accept_timeout", 0, 1);
        end else begin
            logic [63:0] old, mask;
            old = ref_mem.exists(addr) ? ref_mem[addr] : 64'h0;
            if (wen) begin
                mask = '0;
                for (int unsigned i = 0; i < 8; i++) if (wstrb[i]) mask[i*8 +: 8] = 8'hFF;
                ref_mem[addr] = (old & ~mask) | (wdata & mask);
                e.data = 64'h0;
                e.lat  = 3 + aw + w + b;
            end else begin
                e.data = old;
                e.lat  = 3 + ar + r;
            end
            e.req_cyc = cyc;
            sb_q.push_back(e);
        end
        @(negedge clk);
        bus.I_req_valid = 0;
        bus.I_req_wdata = {$urandom, $urandom};
        bus.I_req_addr  = $urandom;
        bus.I_req_wstrb = 8'($urandom);
        bus.I_req_wen   = 1'($urandom);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valids"}, {bus.O_req_ready, bus.O_resp_valid, bus.O_arvalid, bus.O_rready,
                               bus.O_awvalid, bus.O_wvalid, bus.O_bready}, 0);
        chk({tag, "_araddr"}, bus.O_araddr, 0);
        chk({tag, "_awaddr"}, bus.O_awaddr, 0);
        chk({tag, "_wdata"},  bus.O_wdata, 0);
        chk({tag, "_wstrb"},  bus.O_wstrb, 0);
        chk({tag, "_rdata"},  bus.O_resp_rdata, 0);
    endtask

    localparam logic [31:0] CLINT = 32'h0200_4000;

    initial begin
        rst = 1;
        bus.I_req_valid = 0; bus.I_req_wen = 0; bus.I_req_addr = '0;
        bus.I_req_wdata = '0; bus.I_req_wstrb = '0;
        repeat (3) @(negedge clk);
        #1 chk_all_zero("reset");
        @(negedge clk);
        #2 rst = 0;

        do_req(1, CLINT, 64'h0000_0000_0000_0100, 8'hFF, 0, 0, 0, 0, 0, 0);
        do_req(0, CLINT, '0, '0, 0, 0, 0, 0, 0, 0);
        do_req(1, CLINT, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 0, 0, 0, 0, 0, 0);
        do_req(0, CLINT, '0, '0, 0, 0, 0, 0, 0, 0);
        do_req(1, 32'h8000_0010, 64'h1234_5678_9ABC_DEF0, 8'hFF, 0, 0, 1, 1, 0, 0);
        do_req(0, 32'h8000_0010, '0, '0, 3, 2, 0, 0, 0, 0);
        do_req(1, 32'h8000_0018, 64'hA5A5_5A5A_0F0F_F0F0, 8'hC3, 0, 0, 0, 0, 2, 0);
        do_req(0, 32'h8000_0018, '0, '0, 0, 0, 0, 0, 0, 5);
        wait_idle();

        // reset while waiting for read data: nothing may come back afterwards
        do_req(0, 32'h8000_0010, '0, '0, 0, 6, 0, 0, 0, 0);
        for (int unsigned t = 0; t < 20 && !bus.O_rready; t++) @(negedge clk);
        chk("mid_rst_in_R", bus.O_rready, 1);
        #2 rst = 1;
        #1 chk_all_zero("mid_rst");
        sb_q.delete();
        repeat (2) @(negedge clk);
        #2 rst = 0;
        @(negedge clk);
        #1 chk("post_rst_req_ready", bus.O_req_ready, 1);
        do_req(0, 32'h8000_0010, '0, '0, 0, 0, 0, 0, 0, 0);
        wait_idle();

        junk_en = 1;
        for (int unsigned n = 0; n < 40; n++) begin
            logic [31:0] a;
            a = (($urandom_range(3) == 0) ? CLINT : 32'h8000_0000) + 32'($urandom_range(7) * 8);
            do_req(1'($urandom), a, {$urandom, $urandom}, 8'($urandom),
                   $urandom_range(3), $urandom_range(3), $urandom_range(3),
                   $urandom_range(3), $urandom_range(3), $urandom_range(3));
        end
        wait_idle();
        repeat (3) @(negedge clk);
        chk("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
